// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer for the execute stage: evaluates RV32I branch
// conditions, redirects fetch on taken branches and holds a timed flush.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve_ctrl #(
    parameter int VAR_WIDTH    = 32,
    parameter int FLUSH_CYCLES = 2
`ifdef BRANCH_STATS_EN
    ,
    parameter int STAT_WIDTH   = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_func3,
    input  logic [VAR_WIDTH-1:0] req_rs1,
    input  logic [VAR_WIDTH-1:0] req_rs2,
    input  logic [VAR_WIDTH-1:0] req_pc,
    input  logic [12:0]          req_imm,
    input  logic                 kill,
    output logic                 redirect_valid,
    input  logic                 redirect_ready,
    output logic [VAR_WIDTH-1:0] redirect_pc,
    output logic                 flush,
    output logic                 busy,
    output logic                 resolve_valid,
    output logic                 resolve_taken,
    output logic                 resolve_illegal,
    output logic                 resolve_misaligned
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] taken_count,
    output logic [STAT_WIDTH-1:0] nottaken_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_REDIRECT,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t               state_q, state_d;
    logic [2:0]           func3_q;
    logic [VAR_WIDTH-1:0] rs1_q, rs2_q, pc_q;
    logic [12:0]          imm_q;
    logic                 taken_q, illegal_q, mis_q;
    logic [VAR_WIDTH-1:0] target_q;
    logic [3:0]           fcnt_q;

    logic                 eq, lt, ltu;
    logic                 cond_d, illegal_d, mis_d;
    logic [VAR_WIDTH-1:0] target_d;
    logic                 accept, redir_done;

    assign accept     = req_valid && req_ready;
    assign redir_done = (state_q == S_REDIRECT) && redirect_ready && !kill;

    // Condition evaluation and target computation on the latched operands
    always_comb begin
        eq        = (rs1_q == rs2_q);
        lt        = ($signed(rs1_q) < $signed(rs2_q));
        ltu       = (rs1_q < rs2_q);
        cond_d    = 1'b0;
        illegal_d = 1'b0;
        case (func3_q)
            3'b000:  cond_d = eq;
            3'b001:  cond_d = !eq;
            3'b100:  cond_d = lt;
            3'b101:  cond_d = !lt;
            3'b110:  cond_d = ltu;
            3'b111:  cond_d = !ltu;
            default: illegal_d = 1'b1;
        endcase
        target_d = pc_q + {{(VAR_WIDTH-13){imm_q[12]}}, imm_q};
        mis_d    = cond_d && (target_d[1:0] != 2'b00);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; kill aborts any in-flight branch
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (illegal_d || !cond_d || mis_d) state_d = S_DONE;
                else                               state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (redirect_ready) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (fcnt_q <= 4'd1) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (kill && state_q != S_IDLE) state_d = S_IDLE;
    end

    // Output decode from the current state
    always_comb begin
        req_ready          = (state_q == S_IDLE) && !kill;
        busy               = (state_q != S_IDLE);
        redirect_valid     = (state_q == S_REDIRECT);
        redirect_pc        = target_q;
        flush              = (state_q == S_FLUSH);
        resolve_valid      = (state_q == S_DONE) && !kill;
        resolve_taken      = resolve_valid && taken_q;
        resolve_illegal    = resolve_valid && illegal_q;
        resolve_misaligned = resolve_valid && mis_q;
    end

    // Request capture at acceptance, result capture during evaluation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            func3_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            pc_q      <= '0;
            imm_q     <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            mis_q     <= 1'b0;
            target_q  <= '0;
        end else if (accept) begin
            func3_q <= req_func3;
            rs1_q   <= req_rs1;
            rs2_q   <= req_rs2;
            pc_q    <= req_pc;
            imm_q   <= req_imm;
        end else if (state_q == S_EVAL) begin
            taken_q   <= cond_d && !illegal_d;
            illegal_q <= illegal_d;
            mis_q     <= mis_d && !illegal_d;
            target_q  <= target_d;
        end
    end

    // Flush hold counter, loaded when fetch takes the redirect
    always_ff @(posedge clk) begin
        if (!rst_n)                  fcnt_q <= '0;
        else if (redir_done)         fcnt_q <= FLUSH_INIT;
        else if (state_q == S_FLUSH) fcnt_q <= fcnt_q - 4'd1;
    end

`ifdef BRANCH_STATS_EN
    // Saturating taken / not-taken counters, one bump per resolution
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_count    <= '0;
            nottaken_count <= '0;
        end else if (resolve_valid) begin
            if (resolve_taken) begin
                if (taken_count != '1) taken_count <= taken_count + 1'b1;
            end else begin
                if (nottaken_count != '1) nottaken_count <= nottaken_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed, table-driven bench for branch_resolve_ctrl.
// Stats checks compile only when BRANCH_STATS_EN is defined.
module tb_branch_resolve_ctrl;

    localparam int W = 32;
    localparam int F = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_func3;
    logic [W-1:0] req_rs1, req_rs2, req_pc;
    logic [12:0]  req_imm;
    logic         kill;
    logic         redirect_valid;
    logic         redirect_ready;
    logic [W-1:0] redirect_pc;
    logic         flush, busy;
    logic         resolve_valid, resolve_taken;
    logic         resolve_illegal, resolve_misaligned;
`ifdef BRANCH_STATS_EN
    logic [15:0]  taken_count, nottaken_count;
    logic [1:0]   tc2, nc2;
    logic         d2_rr, d2_rv, d2_fl, d2_bz, d2_vv, d2_tk, d2_il, d2_ms;
    logic [W-1:0] d2_pc;
`endif

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.VAR_WIDTH(W), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_func3(req_func3), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_pc(req_pc), .req_imm(req_imm), .kill(kill),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .flush(flush), .busy(busy),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_illegal(resolve_illegal),
        .resolve_misaligned(resolve_misaligned)
`ifdef BRANCH_STATS_EN
        , .taken_count(taken_count), .nottaken_count(nottaken_count)
`endif
    );

`ifdef BRANCH_STATS_EN
    branch_resolve_ctrl #(.VAR_WIDTH(W), .FLUSH_CYCLES(F), .STAT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(d2_rr),
        .req_func3(req_func3), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_pc(req_pc), .req_imm(req_imm), .kill(kill),
        .redirect_valid(d2_rv), .redirect_ready(redirect_ready),
        .redirect_pc(d2_pc), .flush(d2_fl), .busy(d2_bz),
        .resolve_valid(d2_vv), .resolve_taken(d2_tk),
        .resolve_illegal(d2_il), .resolve_misaligned(d2_ms),
        .taken_count(tc2), .nottaken_count(nc2)
    );
`endif

    typedef struct packed {
        logic [2:0]   f3;
        logic [W-1:0] rs1;
        logic [W-1:0] rs2;
        logic [W-1:0] pc;
        logic [12:0]  imm;
        logic         tk;
        logic         il;
        logic         mis;
        logic         rd;
        logic [W-1:0] tgt;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request; returns at cycle 1 (+1) after acceptance
    task automatic issue(input logic [2:0] f3, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] pc,
                         input logic [12:0] imm);
        tick();
        req_valid = 1'b1;
        req_func3 = f3;
        req_rs1   = a;
        req_rs2   = b;
        req_pc    = pc;
        req_imm   = imm;
        @(negedge clk);
        chk("accept_ready", {31'd0, req_ready}, 1);
        tick();
        req_valid = 1'b0;
    endtask

    // Counts resolve pulses / flush cycles over n cycles
    task automatic quiet(input string name, input int n);
        int rv = 0;
        int fl = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (resolve_valid) rv++;
            if (flush) fl++;
            tick();
        end
        chk({name, "_no_resolve"}, rv, 0);
        chk({name, "_no_flush"}, fl, 0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v = vecs[idx];
        int res_cyc = -1;
        int rv = 0;
        int fl = 0;
        int first_rv = -1;
        int first_fl = -1;
        logic [W-1:0] rpc = '0;
        logic tk = 1'b0, il = 1'b0, ms = 1'b0, rdy = 1'b1, bz = 1'b0;
        issue(v.f3, v.rs1, v.rs2, v.pc, v.imm);
        for (int c = 1; c <= 20 && res_cyc < 0; c++) begin
            @(negedge clk);
            if (redirect_valid) begin
                rv++;
                if (first_rv < 0) first_rv = c;
                rpc = redirect_pc;
            end
            if (flush) begin
                fl++;
                if (first_fl < 0) first_fl = c;
            end
            if (resolve_valid) begin
                res_cyc = c;
                tk  = resolve_taken;
                il  = resolve_illegal;
                ms  = resolve_misaligned;
                rdy = req_ready;
                bz  = busy;
            end else begin
                tick();
            end
        end
        chk($sformatf("v%0d_latency", idx), res_cyc, v.rd ? 3 + F : 2);
        chk($sformatf("v%0d_taken", idx), {31'd0, tk}, {31'd0, v.tk});
        chk($sformatf("v%0d_illegal", idx), {31'd0, il}, {31'd0, v.il});
        chk($sformatf("v%0d_misaligned", idx), {31'd0, ms}, {31'd0, v.mis});
        chk($sformatf("v%0d_done_ready", idx), {31'd0, rdy}, 0);
        chk($sformatf("v%0d_done_busy", idx), {31'd0, bz}, 1);
        chk($sformatf("v%0d_redirects", idx), rv, v.rd ? 1 : 0);
        chk($sformatf("v%0d_flushes", idx), fl, v.rd ? F : 0);
        if (v.rd) begin
            chk($sformatf("v%0d_redirect_pc", idx), rpc, v.tgt);
            chk($sformatf("v%0d_redirect_at", idx), first_rv, 2);
            chk($sformatf("v%0d_flush_at", idx), first_fl, 3);
        end
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_ctl"},
            {24'd0, req_ready, busy, flush, redirect_valid, resolve_valid,
             resolve_taken, resolve_illegal, resolve_misaligned},
            32'h80);
        chk({name, "_pc"}, redirect_pc, 0);
    endtask

    initial begin
        //          f3      rs1           rs2           pc            imm       tk il ms rd tgt
        vecs[0]  = '{3'b000, 32'h1234,     32'h1234,     32'h100,      13'h010,  1, 0, 0, 1, 32'h110};
        vecs[1]  = '{3'b100, 32'h80000000, 32'h7FFFFFFF, 32'h200,      13'h020,  1, 0, 0, 1, 32'h220};
        vecs[2]  = '{3'b110, 32'h80000000, 32'h7FFFFFFF, 32'h200,      13'h020,  0, 0, 0, 0, 32'h0};
        vecs[3]  = '{3'b010, 32'h5,        32'h5,        32'h400,      13'h010,  0, 1, 0, 0, 32'h0};
        vecs[4]  = '{3'b101, 32'h5,        32'h5,        32'h300,      13'h002,  1, 0, 1, 0, 32'h0};
        vecs[5]  = '{3'b001, 32'h1,        32'h1,        32'h500,      13'h008,  0, 0, 0, 0, 32'h0};
        vecs[6]  = '{3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h600,      13'h008,  0, 0, 0, 0, 32'h0};
        vecs[7]  = '{3'b000, 32'hABCD,     32'hABCD,     32'h1000,     13'h1FF0, 1, 0, 0, 1, 32'hFF0};
        vecs[8]  = '{3'b011, 32'h1,        32'h2,        32'h700,      13'h010,  0, 1, 0, 0, 32'h0};
        vecs[9]  = '{3'b101, 32'hFFFFFFFF, 32'h0,        32'h800,      13'h010,  0, 0, 0, 0, 32'h0};
        vecs[10] = '{3'b001, 32'h3,        32'h3,        32'h0,        13'h002,  0, 0, 0, 0, 32'h0};

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_func3 = '0;
        req_rs1 = '0;
        req_rs2 = '0;
        req_pc = '0;
        req_imm = '0;
        kill = 1'b0;
        redirect_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk_reset_outs("reset");
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i);

        // kill while idle blocks acceptance
        tick();
        kill = 1'b1;
        @(negedge clk);
        chk("idle_kill_ready", {31'd0, req_ready}, 0);
        tick();
        kill = 1'b0;

        // Stalled redirect with wrap-around target
        redirect_ready = 1'b0;
        issue(3'b001, 32'h1, 32'h2, 32'h0, 13'h1FFC);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", k), {31'd0, redirect_valid}, 1);
            chk($sformatf("stall%0d_pc", k), redirect_pc, 32'hFFFFFFFC);
            chk($sformatf("stall%0d_flush", k), {31'd0, flush}, 0);
            tick();
        end
        redirect_ready = 1'b1;
        @(negedge clk);
        chk("stall_hs_valid", {31'd0, redirect_valid}, 1);
        chk("stall_hs_flush", {31'd0, flush}, 0);
        tick();
        redirect_ready = 1'b0;
        @(negedge clk);
        chk("stall_flush1", {31'd0, flush, redirect_valid}, 2);
        tick();
        @(negedge clk);
        chk("stall_flush2", {31'd0, flush}, 1);
        tick();
        @(negedge clk);
        chk("stall_resolve", {30'd0, resolve_valid, resolve_taken}, 3);
        tick();
        redirect_ready = 1'b1;

        // kill together with redirect_ready in REDIRECT
        issue(3'b000, 32'h7, 32'h7, 32'h40, 13'h008);
        tick();
        kill = 1'b1;
        @(negedge clk);
        chk("killrd_valid", {31'd0, redirect_valid}, 1);
        tick();
        kill = 1'b0;
        @(negedge clk);
        chk("killrd_after", {29'd0, redirect_valid, flush, busy}, 0);
        quiet("killrd", 5);

        // kill during FLUSH
        issue(3'b000, 32'h7, 32'h7, 32'h40, 13'h008);
        tick();
        tick();
        kill = 1'b1;
        @(negedge clk);
        chk("killfl_flush", {31'd0, flush}, 1);
        tick();
        kill = 1'b0;
        @(negedge clk);
        chk("killfl_after", {29'd0, flush, busy, resolve_valid}, 0);
        quiet("killfl", 5);

        // Reset during FLUSH
        issue(3'b000, 32'h7, 32'h7, 32'h40, 13'h008);
        tick();
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstfl_flush", {31'd0, flush}, 1);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outs("rstfl");
        quiet("rstfl", 5);

`ifdef BRANCH_STATS_EN
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("stat_reset", {taken_count, nottaken_count}, 0);
        for (int i = 0; i < 3; i++) run_vec(0);
        for (int i = 0; i < 2; i++) run_vec(2);
        issue(3'b000, 32'h7, 32'h7, 32'h40, 13'h008);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        quiet("stat_kill", 4);
        @(negedge clk);
        chk("stat_taken", {16'd0, taken_count}, 3);
        chk("stat_nottaken", {16'd0, nottaken_count}, 2);
        chk("stat2_taken", {30'd0, tc2}, 3);
        chk("stat2_nottaken", {30'd0, nc2}, 2);
        for (int i = 0; i < 5; i++) run_vec(0);
        @(negedge clk);
        chk("stat_taken8", {16'd0, taken_count}, 8);
        chk("stat2_saturated", {30'd0, tc2}, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequencer for the branch comparison datapath in the execute stage.
- Accepts one conditional-branch request at a time, evaluates the RV32I branch condition selected by func3, and computes the branch target.
- On a taken branch: issues a PC redirect to fetch under a valid/ready handshake, then asserts a timed pipeline flush.
- Always reports a one-cycle resolution status to the hazard/exception logic.

Parameters:
- VAR_WIDTH, 32, width of rs1/rs2/pc/target.
- FLUSH_CYCLES, 2, number of cycles flush is held after the redirect is accepted; legal range 1..15.
- STAT_WIDTH, 16, width of statistics counters (optional feature only).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  branch request present.
- req_ready  out  1  controller can accept a request.
- req_func3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- req_rs1  in  VAR_WIDTH  operand 1.
- req_rs2  in  VAR_WIDTH  operand 2.
- req_pc  in  VAR_WIDTH  PC of the branch instruction.
- req_imm  in  13  B-type immediate, bit 0 always 0, sign bit 12.
- kill  in  1  abort the in-flight branch (older exception/flush).
- redirect_valid  out  1  redirect target presented to fetch.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  VAR_WIDTH  branch target.
- flush  out  1  squash younger pipeline stages.
- busy  out  1  high in every state except IDLE.
- resolve_valid  out  1  one-cycle resolution pulse.
- resolve_taken  out  1  branch condition true.
- resolve_illegal  out  1  func3 was 010 or 011.
- resolve_misaligned  out  1  taken target not 4-byte aligned.

Behaviour:
- Reset (rst_n=0 at posedge):
  - State goes to IDLE; flush counter clears.
  - All outputs 0 except req_ready=1; redirect_pc=0.
- States: IDLE, EVAL, REDIRECT, FLUSH, DONE.
- IDLE:
  - req_ready = ~kill.
  - On req_valid && req_ready: register func3/rs1/rs2/pc/imm and go to EVAL.
- EVAL (one cycle):
  - Comparison:
    - BEQ/BNE use equality.
    - BLT/BGE use signed compare.
    - BLTU/BGEU use unsigned compare.
  - Target = pc + sign_extend(imm) modulo 2^VAR_WIDTH; wrap-around is silently allowed.
  - Register taken, illegal, misaligned (= taken && target[1:0] != 0), and target.
  - Illegal func3: taken forced 0, go to DONE.
  - Taken and misaligned: no redirect, go to DONE.
  - Taken and aligned: go to REDIRECT.
  - Not taken: go to DONE.
- REDIRECT:
  - redirect_valid=1; redirect_pc stable until the handshake.
  - On redirect_ready: load flush counter with FLUSH_CYCLES and go to FLUSH.
  - redirect_ready already high on entry: handshake completes that same cycle.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles; counter decrements each cycle.
  - Counter reaching 1 goes to DONE.
- DONE:
  - resolve_valid=1 for one cycle with registered taken/illegal/misaligned, then go to IDLE.
  - req_ready=0 in DONE.
- Latency:
  - Not-taken: resolve_valid exactly 2 cycles after acceptance.
  - Taken with immediate redirect_ready: redirect_valid at +2, flush +3..+2+FLUSH_CYCLES, resolve_valid at +3+FLUSH_CYCLES.
- Back-to-back requests:
  - Next request is accepted no earlier than the cycle after DONE; throughput is one branch per ≥3 cycles.
- kill:
  - In any non-IDLE state, kill forces IDLE next cycle.
  - No resolve_valid is issued.
  - redirect_valid and flush drop on that edge.
  - kill in the same cycle as redirect_ready in REDIRECT: kill wins, no FLUSH phase.
- Reset mid-operation: identical to power-up reset; no pulse is issued.
- Signed compare of 0x80000000 vs 0x7FFFFFFF: less-than. Unsigned compare of the same pair: greater.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs taken_count and nottaken_count [STAT_WIDTH-1:0], both reset to 0.
  - On each resolve_valid, exactly one counter increments: taken_count if resolve_taken, else nottaken_count. Illegal branches count as not-taken.
  - Counters saturate at all-ones.
  - Killed branches are not counted.
- Undefined: ports and counters are absent; all other behaviour is unchanged.

Test Plan:
- BEQ, rs1=rs2=0x1234, pc=0x100, imm=0x010, redirect_ready=1:
  - redirect_valid at +2 with redirect_pc=0x110.
  - flush high 2 cycles.
  - resolve_valid with taken=1 at +5.
- BLT rs1=0x80000000, rs2=0x7FFFFFFF -> taken. BLTU with the same operands -> not taken, resolve_valid at +2, no redirect, no flush.
- BNE taken, imm=0x1FFC (−4), pc=0x0 -> redirect_pc=0xFFFFFFFC (wrap). Hold redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc stable throughout; flush starts the cycle after ready.
- func3=010 -> resolve_illegal=1, taken=0, no redirect. Taken BGE with imm=0x002 -> resolve_misaligned=1, no redirect/flush.
- kill asserted in REDIRECT and in FLUSH -> IDLE next cycle, flush/redirect_valid drop, no resolve_valid. rst_n=0 mid-FLUSH -> all outputs at reset values next cycle.
- BRANCH_STATS_EN: 3 taken, 2 not-taken, 1 killed -> taken_count=3, nottaken_count=2. With STAT_WIDTH=2 and 5 taken -> taken_count stays 3.
